// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   XLEN-wide, NREGS-deep register file with two combinational read ports,
//   one byte-enabled write-back port with same-cycle forwarding, and a
//   per-register busy scoreboard. Long-latency units reserve a destination at
//   issue and release it at write-back. Register 0 reads as zero; register
//   SP_IDX resets to SP_INIT.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   rd_addr1/2   read addresses
//   rd_data1/2   read data (combinational, forwarded from write-back)
//   rd_ready1/2  read data valid (no pending write to that register)
//   issue_valid  request to reserve issue_rd
//   issue_rd     destination to reserve
//   issue_ready  reservation can be accepted this cycle
//   wb_valid     write-back strobe
//   wb_addr      write-back destination
//   wb_data      write-back data
//   wb_be        byte enables, bit i covers wb_data[8i+7:8i]
//   pending_cnt  number of busy registers

module regfile_scoreboard #(
   parameter int               XLEN    = 32,
   parameter int               NREGS   = 32,
   parameter int               SP_IDX  = 29,
   parameter logic [XLEN-1:0]  SP_INIT = XLEN'(32'h0000_07fc),
   localparam int              AW      = $clog2(NREGS),
   localparam int              NB      = XLEN / 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rd_addr1,
   input  logic [AW-1:0]   rd_addr2,
   output logic [XLEN-1:0] rd_data1,
   output logic [XLEN-1:0] rd_data2,
   output logic            rd_ready1,
   output logic            rd_ready2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [NB-1:0]   wb_be,
   output logic [AW:0]     pending_cnt
);

   // SP_IDX = 0 (or out of range) means no register has a special reset value.
   localparam bit            SP_EN   = (SP_IDX != 0) && (SP_IDX < NREGS);
   localparam logic [AW-1:0] SP_ADDR = AW'(SP_IDX);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic [AW:0]      cnt;
   logic             wb_en;
   logic             issue_acc;
   logic             cnt_inc;
   logic             cnt_dec;

   function automatic logic [XLEN-1:0] byte_merge(
      input logic [XLEN-1:0] old_val,
      input logic [XLEN-1:0] new_val,
      input logic [NB-1:0]   be
   );
      logic [XLEN-1:0] res;
      res = old_val;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   function automatic logic [XLEN-1:0] reset_value(input logic [AW-1:0] addr);
      return (SP_EN && addr == SP_ADDR) ? SP_INIT : '0;
   endfunction

   // Returns {ready, data}. While reset is asserted the port shows the reset
   // contents so decode never sees stale pre-reset state.
   function automatic logic [XLEN:0] read_port(
      input logic            rst,
      input logic [AW-1:0]   addr,
      input logic [XLEN-1:0] stored,
      input logic            stored_busy,
      input logic            fwd_valid,
      input logic [AW-1:0]   fwd_addr,
      input logic [XLEN-1:0] fwd_data,
      input logic [NB-1:0]   fwd_be
   );
      if (rst)
         return {1'b1, reset_value(addr)};
      else if (addr == '0)
         return {1'b1, {XLEN{1'b0}}};
      else if (fwd_valid && fwd_addr == addr)
         return {1'b1, byte_merge(stored, fwd_data, fwd_be)};
      else
         return {~stored_busy, stored};
   endfunction

   assign wb_en     = wb_valid && (wb_addr != '0);
   // An accepted nonzero issue always targets a non-busy register, so it is
   // always a 0->1 transition of busy.
   assign issue_acc = issue_valid && (issue_rd != '0) && !busy[issue_rd];
   assign cnt_inc   = issue_acc;
   // A wb to the register being issued this cycle is never busy (issue would
   // have been refused), so no same-register correction is needed here.
   assign cnt_dec   = wb_en && busy[wb_addr];

   always_comb begin
      busy_next = busy;
      if (wb_en)     busy_next[wb_addr]  = 1'b0;
      if (issue_acc) busy_next[issue_rd] = 1'b1;   // set beats clear
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= reset_value(AW'(i));
         end
         busy <= '0;
         cnt  <= '0;
      end else begin
         if (wb_en) regs[wb_addr] <= byte_merge(regs[wb_addr], wb_data, wb_be);
         busy <= busy_next;
         cnt  <= cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
      end
   end

   assign {rd_ready1, rd_data1} = read_port(reset, rd_addr1, regs[rd_addr1], busy[rd_addr1],
                                            wb_valid, wb_addr, wb_data, wb_be);
   assign {rd_ready2, rd_data2} = read_port(reset, rd_addr2, regs[rd_addr2], busy[rd_addr2],
                                            wb_valid, wb_addr, wb_data, wb_be);

   assign issue_ready = reset || (issue_rd == '0) || !busy[issue_rd];
   assign pending_cnt = reset ? '0 : cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios plus randomized
// traffic checked against a behavioural register/scoreboard model.

module tb_regfile_scoreboard;

   localparam int          XLEN    = 32;
   localparam int          NREGS   = 32;
   localparam int          AW      = 5;
   localparam int          NB      = 4;
   localparam int          SP      = 29;
   localparam logic [31:0] SP_INIT = 32'h0000_07fc;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   rd_addr1, rd_addr2;
   logic [XLEN-1:0] rd_data1, rd_data2;
   logic            rd_ready1, rd_ready2;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            issue_ready;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic [NB-1:0]   wb_be;
   logic [AW:0]     pending_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_regs [NREGS];
   bit          m_busy [NREGS];

   regfile_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .rd_data1    (rd_data1),
      .rd_data2    (rd_data2),
      .rd_ready1   (rd_ready1),
      .rd_ready2   (rd_ready2),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_be       (wb_be),
      .pending_cnt (pending_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return {b[3], b[2], b[1], b[0]};
   endfunction

   task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d, output logic r);
      if (reset) begin
         d = (a == SP) ? SP_INIT : 32'h0;
         r = 1'b1;
      end else if (a == 0) begin
         d = 32'h0;
         r = 1'b1;
      end else if (wb_valid && wb_addr == a) begin
         d = m_merge(m_regs[a], wb_data, wb_be);
         r = 1'b1;
      end else begin
         d = m_regs[a];
         r = !m_busy[a];
      end
   endtask

   function automatic int model_pending();
      int c = 0;
      if (reset) return 0;
      for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic logic model_issue_ready();
      return reset || issue_rd == 0 || !m_busy[issue_rd];
   endfunction

   // Apply the edge to the model, then advance the DUT one clock.
   task automatic step();
      bit acc;
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = (i == SP) ? SP_INIT : 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         acc = issue_valid && (issue_rd == 0 || !m_busy[issue_rd]);
         if (wb_valid && wb_addr != 0) begin
            m_regs[wb_addr] = m_merge(m_regs[wb_addr], wb_data, wb_be);
            m_busy[wb_addr] = 1'b0;
         end
         if (acc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset       = 1'b0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      wb_valid    = 1'b0;
      wb_addr     = '0;
      wb_data     = '0;
      wb_be       = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      reset    = 1'b1;
      rd_addr1 = 5'd29;
      rd_addr2 = 5'd5;
      issue_rd = 5'd29;
      #2;
      n_checks++; if (rd_data1 !== 32'h7fc) $display("FAIL in_reset_rd29 got %h exp %h", rd_data1, 32'h7fc); else n_pass++;
      n_checks++; if (issue_ready !== 1'b1) $display("FAIL in_reset_issue_ready got %b exp 1", issue_ready); else n_pass++;
      step();
      reset = 1'b0;
      #2;
      n_checks++; if (rd_data1 !== 32'h7fc) $display("FAIL reset_rd29 got %h exp %h", rd_data1, 32'h7fc); else n_pass++;
      n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL reset_ready29 got %b exp 1", rd_ready1); else n_pass++;
      n_checks++; if (rd_data2 !== 32'h0) $display("FAIL reset_rd5 got %h exp 0", rd_data2); else n_pass++;
      n_checks++; if (rd_ready2 !== 1'b1) $display("FAIL reset_ready5 got %b exp 1", rd_ready2); else n_pass++;
      n_checks++; if (pending_cnt !== 6'd0) $display("FAIL reset_pending got %0d exp 0", pending_cnt); else n_pass++;
      step();
   endtask

   task automatic test_raw();
      idle();
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      rd_addr1    = 5'd7;
      #2;
      n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL raw_c0_ready got %b exp 1", rd_ready1); else n_pass++;
      step();
      issue_valid = 1'b0;
      #2;
      n_checks++; if (rd_ready1 !== 1'b0) $display("FAIL raw_c1_ready got %b exp 0", rd_ready1); else n_pass++;
      n_checks++; if (issue_ready !== 1'b0) $display("FAIL raw_c1_issue_ready got %b exp 0", issue_ready); else n_pass++;
      n_checks++; if (pending_cnt !== 6'd1) $display("FAIL raw_c1_pending got %0d exp 1", pending_cnt); else n_pass++;
      step();
      wb_valid = 1'b1;
      wb_addr  = 5'd7;
      wb_data  = 32'hDEADBEEF;
      wb_be    = 4'hF;
      #2;
      n_checks++; if (rd_data1 !== 32'hDEADBEEF) $display("FAIL raw_fwd_data got %h exp deadbeef", rd_data1); else n_pass++;
      n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL raw_fwd_ready got %b exp 1", rd_ready1); else n_pass++;
      step();
      idle();
      #2;
      n_checks++; if (rd_data1 !== 32'hDEADBEEF) $display("FAIL raw_stored_data got %h exp deadbeef", rd_data1); else n_pass++;
      n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL raw_stored_ready got %b exp 1", rd_ready1); else n_pass++;
      n_checks++; if (pending_cnt !== 6'd0) $display("FAIL raw_pending got %0d exp 0", pending_cnt); else n_pass++;
   endtask

   task automatic test_byte_merge();
      idle();
      wb_valid = 1'b1;
      wb_addr  = 5'd3;
      wb_data  = 32'h11223344;
      wb_be    = 4'hF;
      step();
      wb_data  = 32'hAABBCCDD;
      wb_be    = 4'b0101;
      rd_addr2 = 5'd3;
      #2;
      n_checks++; if (rd_data2 !== 32'h11BB33DD) $display("FAIL merge_fwd got %h exp 11bb33dd", rd_data2); else n_pass++;
      step();
      idle();
      #2;
      n_checks++; if (rd_data2 !== 32'h11BB33DD) $display("FAIL merge_stored got %h exp 11bb33dd", rd_data2); else n_pass++;
   endtask

   task automatic test_zero_reg();
      int p;
      idle();
      p           = model_pending();
      wb_valid    = 1'b1;
      wb_addr     = 5'd0;
      wb_data     = 32'hFFFFFFFF;
      wb_be       = 4'hF;
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      rd_addr1    = 5'd0;
      #2;
      n_checks++; if (rd_data1 !== 32'h0) $display("FAIL zero_fwd_data got %h exp 0", rd_data1); else n_pass++;
      n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL zero_ready got %b exp 1", rd_ready1); else n_pass++;
      n_checks++; if (issue_ready !== 1'b1) $display("FAIL zero_issue_ready got %b exp 1", issue_ready); else n_pass++;
      step();
      idle();
      #2;
      n_checks++; if (rd_data1 !== 32'h0) $display("FAIL zero_stored got %h exp 0", rd_data1); else n_pass++;
      n_checks++; if (int'(pending_cnt) !== p) $display("FAIL zero_pending got %0d exp %0d", pending_cnt, p); else n_pass++;
   endtask

   task automatic test_simultaneous();
      idle();
      issue_valid = 1'b1;
      issue_rd    = 5'd4;
      step();
      issue_rd = 5'd9;
      wb_valid = 1'b1;
      wb_addr  = 5'd4;
      wb_data  = $urandom;
      wb_be    = 4'hF;
      step();
      idle();
      rd_addr1 = 5'd9;
      rd_addr2 = 5'd4;
      #2;
      n_checks++; if (pending_cnt !== 6'd1) $display("FAIL simul_pending got %0d exp 1", pending_cnt); else n_pass++;
      n_checks++; if (rd_ready1 !== 1'b0) $display("FAIL simul_busy9 got ready %b exp 0", rd_ready1); else n_pass++;
      n_checks++; if (rd_ready2 !== 1'b1) $display("FAIL simul_busy4 got ready %b exp 1", rd_ready2); else n_pass++;
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      wb_valid    = 1'b1;
      wb_addr     = 5'd5;
      wb_data     = 32'h0000_0055;
      wb_be       = 4'hF;
      step();
      idle();
      rd_addr1 = 5'd5;
      #2;
      n_checks++; if (rd_ready1 !== 1'b0) $display("FAIL same_busy5 got ready %b exp 0", rd_ready1); else n_pass++;
      n_checks++; if (rd_data1 !== 32'h55) $display("FAIL same_data5 got %h exp 55", rd_data1); else n_pass++;
      n_checks++; if (pending_cnt !== 6'd2) $display("FAIL same_pending got %0d exp 2", pending_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] res_list [3];
      res_list = '{5'd2, 5'd6, 5'd29};
      idle();
      issue_valid = 1'b1;
      foreach (res_list[i]) begin
         issue_rd = res_list[i];
         step();
      end
      idle();
      #2;
      n_checks++; if (int'(pending_cnt) !== model_pending()) $display("FAIL mid_pending_before got %0d exp %0d", pending_cnt, model_pending()); else n_pass++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      foreach (res_list[i]) begin
         rd_addr1 = res_list[i];
         #1;
         n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL mid_ready r%0d got %b exp 1", res_list[i], rd_ready1); else n_pass++;
      end
      rd_addr2 = 5'd29;
      #1;
      n_checks++; if (rd_data2 !== 32'h7fc) $display("FAIL mid_rd29 got %h exp 7fc", rd_data2); else n_pass++;
      n_checks++; if (pending_cnt !== 6'd0) $display("FAIL mid_pending_after got %0d exp 0", pending_cnt); else n_pass++;
      wb_valid = 1'b1;
      wb_addr  = 5'd6;
      wb_data  = 32'h5;
      wb_be    = 4'hF;
      step();
      idle();
      rd_addr1 = 5'd6;
      #2;
      n_checks++; if (rd_data1 !== 32'h5) $display("FAIL late_wb_data got %h exp 5", rd_data1); else n_pass++;
      n_checks++; if (rd_ready1 !== 1'b1) $display("FAIL late_wb_ready got %b exp 1", rd_ready1); else n_pass++;
      n_checks++; if (pending_cnt !== 6'd0) $display("FAIL late_wb_pending got %0d exp 0", pending_cnt); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] ed1, ed2;
      logic        er1, er2;
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 49) == 0);
         issue_valid = $urandom_range(0, 1) == 1;
         issue_rd    = AW'($urandom_range(0, 7));
         wb_valid    = $urandom_range(0, 1) == 1;
         wb_addr     = ($urandom_range(0, 9) == 0) ? 5'd29 : AW'($urandom_range(0, 7));
         wb_data     = $urandom;
         wb_be       = NB'($urandom_range(0, 15));
         rd_addr1    = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom_range(0, 7));
         rd_addr2    = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, 7));
         #2;
         model_read(rd_addr1, ed1, er1);
         model_read(rd_addr2, ed2, er2);
         n_checks++; if (rd_data1 !== ed1) $display("FAIL rand_data1 c%0d a%0d got %h exp %h", c, rd_addr1, rd_data1, ed1); else n_pass++;
         n_checks++; if (rd_ready1 !== er1) $display("FAIL rand_ready1 c%0d a%0d got %b exp %b", c, rd_addr1, rd_ready1, er1); else n_pass++;
         n_checks++; if (rd_data2 !== ed2) $display("FAIL rand_data2 c%0d a%0d got %h exp %h", c, rd_addr2, rd_data2, ed2); else n_pass++;
         n_checks++; if (rd_ready2 !== er2) $display("FAIL rand_ready2 c%0d a%0d got %b exp %b", c, rd_addr2, rd_ready2, er2); else n_pass++;
         n_checks++; if (issue_ready !== model_issue_ready()) $display("FAIL rand_issue_ready c%0d got %b exp %b", c, issue_ready, model_issue_ready()); else n_pass++;
         n_checks++; if (int'(pending_cnt) !== model_pending()) $display("FAIL rand_pending c%0d got %0d exp %0d", c, pending_cnt, model_pending()); else n_pass++;
         step();
      end
      idle();
   endtask

   initial begin
      idle();
      rd_addr1 = '0;
      rd_addr2 = '0;
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      test_reset();
      test_raw();
      test_byte_merge();
      test_zero_reg();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
